// File: rtl/cycle_counter.sv
// Packed-BCD measurement counter: accumulates increment pulses between trigger and stop,
// latches the final count with a one-cycle valid strobe, saturates at all-nines.
module cycle_counter #(
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    trigger_i,
  input  logic                    stop_i,
  input  logic                    increment_i,
  output logic [4*NUM_DIGITS-1:0] count_bcd_o,
  output logic [4*NUM_DIGITS-1:0] result_bcd_o,
  output logic                    result_valid_o,
  output logic                    overflow_o,
  output logic                    busy_o
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_count, w_count_nxt;
  logic [W-1:0]   r_result, w_result_nxt;
  logic           r_overflow, w_overflow_nxt;
  logic           r_valid, r_busy;
  logic [W-1:0]   w_count_inc;

  // Ripple the carry from digit 0 upward; a 9 under a carry wraps to 0.
  function automatic logic [W-1:0] bcd_incr(input logic [W-1:0] v);
    logic       carry;
    logic [3:0] d;
    bcd_incr = v;
    carry    = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = v[4*k +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          bcd_incr[4*k +: 4] = 4'd0;
        end else begin
          bcd_incr[4*k +: 4] = d + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  endfunction

  assign w_count_inc = bcd_incr(r_count);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;
    unique case (r_state)
      IDLE: begin
        if (trigger_i) begin
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
          w_state_nxt    = COUNT;
        end
      end
      COUNT: begin
        if (increment_i) begin
          if (r_count == ALL_NINES) w_overflow_nxt = 1'b1;
          else                      w_count_nxt    = w_count_inc;
        end
        // Stop captures the post-increment value and overrides any trigger.
        if (stop_i) begin
          w_result_nxt = w_count_nxt;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        if (trigger_i) begin
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
          w_state_nxt    = COUNT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_result   <= w_result_nxt;
      r_overflow <= w_overflow_nxt;
      r_valid    <= (w_state_nxt == DONE);
      r_busy     <= (w_state_nxt == COUNT);
    end
  end

  assign count_bcd_o    = r_count;
  assign result_bcd_o   = r_result;
  assign result_valid_o = r_valid;
  assign overflow_o     = r_overflow;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_cycle_counter.sv
// Self-checking bench for cycle_counter: integer-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_cycle_counter;

  localparam int ND  = 3;
  localparam int W   = 4 * ND;
  localparam int MAX = 999;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         trigger = 1'b0, stop = 1'b0, increment = 1'b0;
  logic [W-1:0] count_bcd, result_bcd;
  logic         result_valid, overflow, busy;

  int n_compared = 0;
  int n_mismatched = 0;

  cycle_counter #(.NUM_DIGITS(ND)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .trigger_i      (trigger),
    .stop_i         (stop),
    .increment_i    (increment),
    .count_bcd_o    (count_bcd),
    .result_bcd_o   (result_bcd),
    .result_valid_o (result_valid),
    .overflow_o     (overflow),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers; phase 0 = idle, 1 = measuring, 2 = result just latched.
  int m_phase = 0;
  int m_count = 0;
  int m_result = 0;
  bit m_ovf = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_count = 0; m_result = 0; m_ovf = 1'b0;
    end else begin
      case (m_phase)
        0: if (trigger) begin m_count = 0; m_ovf = 1'b0; m_phase = 1; end
        1: begin
          if (increment) begin
            if (m_count == MAX) m_ovf = 1'b1;
            else m_count = m_count + 1;
          end
          if (stop) begin m_result = m_count; m_phase = 2; end
        end
        default: begin
          if (trigger) begin m_count = 0; m_ovf = 1'b0; m_phase = 1; end
          else m_phase = 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are stable on the falling edge.
  always @(negedge clk) begin
    check("model.count",  32'(count_bcd),    32'(to_bcd(m_count)));
    check("model.result", 32'(result_bcd),   32'(to_bcd(m_result)));
    check("model.valid",  32'(result_valid), 32'(m_phase == 2));
    check("model.busy",   32'(busy),         32'(m_phase == 1));
    check("model.ovf",    32'(overflow),     32'(m_ovf));
    for (int k = 0; k < ND; k++)
      if (count_bcd[4*k +: 4] > 4'd9) check("digit_le_9", 32'(count_bcd[4*k +: 4]), 32'd9);
  end

  // One clock: drive after the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input bit t, input bit s, input bit i);
    @(negedge clk);
    trigger = t; stop = s; increment = i;
    @(posedge clk);
    #1;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", 32'(count_bcd), 32'h0);
    check("rst.result", 32'(result_bcd), 32'h0);
    check("rst.flags", {29'd0, result_valid, overflow, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic measurement
    cyc(1, 0, 0);
    check("t1.busy", 32'(busy), 32'h1);
    incs(5);
    cyc(0, 1, 0);
    check("t1.result", 32'(result_bcd), 32'h005);
    check("t1.valid", 32'(result_valid), 32'h1);
    check("t1.busy_low", 32'(busy), 32'h0);
    check("t1.ovf", 32'(overflow), 32'h0);
    cyc(0, 0, 0);
    check("t1.valid_drop", 32'(result_valid), 32'h0);

    // BCD carries
    cyc(1, 0, 0);
    incs(9);   check("t2.9",   32'(count_bcd), 32'h009);
    incs(1);   check("t2.10",  32'(count_bcd), 32'h010);
    incs(89);  check("t2.99",  32'(count_bcd), 32'h099);
    incs(1);   check("t2.100", 32'(count_bcd), 32'h100);

    // Saturation, then back-to-back trigger from DONE
    cyc(1, 0, 0);
    incs(1000);
    check("t3.sat", 32'(count_bcd), 32'h999);
    check("t3.ovf", 32'(overflow), 32'h1);
    cyc(0, 1, 0);
    check("t3.result", 32'(result_bcd), 32'h999);
    cyc(1, 0, 0);
    check("t3.retrig_busy", 32'(busy), 32'h1);
    check("t3.retrig_count", 32'(count_bcd), 32'h000);
    check("t3.retrig_ovf", 32'(overflow), 32'h0);
    check("t3.result_hold", 32'(result_bcd), 32'h999);

    // Simultaneous events
    incs(41);
    cyc(0, 1, 1);
    check("t4.stop_inc", 32'(result_bcd), 32'h042);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    incs(3);
    cyc(1, 1, 0);
    check("t4.stop_trig_valid", 32'(result_valid), 32'h1);
    check("t4.stop_trig_count", 32'(count_bcd), 32'h003);
    check("t4.stop_trig_busy", 32'(busy), 32'h0);

    // Ignored inputs
    cyc(0, 0, 1);
    check("t5.inc_done", 32'(count_bcd), 32'h003);
    cyc(0, 1, 1);
    check("t5.idle_ignored", {19'd0, result_valid, count_bcd}, 32'h0003);
    cyc(1, 0, 0);
    incs(2);
    cyc(1, 0, 1);
    check("t5.trig_in_count", 32'(count_bcd), 32'h003);
    check("t5.trig_busy", 32'(busy), 32'h1);

    // Mid-run asynchronous reset
    incs(120);
    check("t6.123", 32'(count_bcd), 32'h123);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.async_count", 32'(count_bcd), 32'h0);
    check("t6.async_result", 32'(result_bcd), 32'h0);
    check("t6.async_flags", {29'd0, result_valid, overflow, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    incs(3);
    check("t6.ignored", {19'd0, busy, count_bcd}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(99) < 6), ($urandom_range(99) < 3), ($urandom_range(99) < 70));
      if ($urandom_range(999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
